// File: rtl/clic_target_pkg.sv
// Shared types for the CLIC hart-side interrupt target: saved-context record and privilege encodings.
package clic_target_pkg;

    // Context id field is sized for the largest CLIC source count; the top narrows it to SRC_W.
    localparam int CLIC_ID_W = 12;
    localparam int CNT_W     = 16;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef struct packed {
        logic [1:0]           priv;
        logic [7:0]           level;
        logic [CLIC_ID_W-1:0] id;
        logic                 shv;
        logic [CNT_W-1:0]     cnt;
    } ctx_t;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Unimplemented low level bits read as ones.
    function automatic logic [7:0] eff_level(input logic [7:0] lvl, input int intctlbits);
        logic [7:0] r;
        r = lvl;
        for (int i = 0; i < 8; i++) begin
            if (i < 8 - intctlbits) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clic_ctx_stack.sv
// LIFO of preempted interrupt contexts; top entry is read combinationally for a same-edge restore.
module clic_ctx_stack
    import clic_target_pkg::*;
#(
    parameter int  NEST_DEPTH = 4,
    localparam int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  ctx_t               push_ctx_i,
    output ctx_t               top_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [DEPTH_W-1:0] depth_o
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    ctx_t               entry_rd [NEST_DEPTH];

    assign full_o  = (depth_q == DEPTH_W'(NEST_DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    generate
        for (genvar gi = 0; gi < NEST_DEPTH; gi++) begin : g_entry
            ctx_t entry_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else if (push_i && !full_o && depth_q == DEPTH_W'(gi)) begin
                    entry_q <= push_ctx_i;
                end
            end

            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        top_o = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) top_o = entry_rd[i];
        end
    end

    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) depth_q <= '0;
        else        depth_q <= depth_d;
    end

endmodule

// File: rtl/clic_irq_target.sv
// Hart-side CLIC interrupt target: accepts only preempting requests, nests contexts on a LIFO,
// runs each handler for SVC_CYCLES cycles and then models xRET by restoring the preempted context.
module clic_irq_target
    import clic_target_pkg::*;
#(
    parameter int         N_SOURCE   = 256,
    parameter int         INTCTLBITS = 8,
    parameter int         NEST_DEPTH = 4,
    parameter int         SVC_CYCLES = 16,
    parameter logic [1:0] BASE_PRIV  = 2'b00,
    localparam int        SRC_W      = $clog2(N_SOURCE),
    localparam int        DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               irq_valid_i,
    output logic               irq_ready_o,
    input  logic [SRC_W-1:0]   irq_id_i,
    input  logic [7:0]         irq_level_i,
    input  logic               irq_shv_i,
    input  logic [1:0]         irq_priv_i,
    input  logic [7:0]         mintthresh_i,
    input  logic [7:0]         sintthresh_i,
    input  logic               mie_i,
    input  logic               sie_i,
    output logic [1:0]         cur_priv_o,
    output logic [7:0]         cur_level_o,
    output logic [SRC_W-1:0]   cur_id_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               taken_o,
    output logic               taken_shv_o,
    output logic               done_o,
    output logic [SRC_W-1:0]   done_id_o
);

    localparam ctx_t BG_CTX = '{priv: BASE_PRIV, level: 8'd0, id: '0, shv: 1'b0, cnt: '0};

    ctx_t             cur_q, cur_d;
    ctx_t             push_ctx;
    ctx_t             stack_top;
    logic             stack_full, stack_empty;
    logic             push, pop;
    logic             taken_q, taken_d;
    logic             taken_shv_q, taken_shv_d;
    logic             done_q, done_d;
    logic [SRC_W-1:0] done_id_q, done_id_d;

    logic [7:0] lvl_eff;
    logic [7:0] thr;
    logic       gie;
    logic       preempt;
    logic       in_handler;
    logic       finishing;
    logic       accept;

    assign lvl_eff    = eff_level(irq_level_i, INTCTLBITS);
    assign thr        = (irq_priv_i == PRIV_M) ? mintthresh_i : sintthresh_i;
    assign in_handler = !stack_empty;
    assign finishing  = in_handler && (cur_q.cnt == CNT_W'(1));

    always_comb begin
        case (cur_q.priv)
            PRIV_M:  gie = mie_i;
            PRIV_S:  gie = sie_i;
            default: gie = 1'b0;
        endcase
    end

    // Higher privilege only has to clear its threshold; same privilege must also beat the running level.
    assign preempt = (lvl_eff != 8'd0) &&
                     (((irq_priv_i > cur_q.priv) && (lvl_eff > thr)) ||
                      ((irq_priv_i == cur_q.priv) && gie && (lvl_eff > max8(cur_q.level, thr))));

    assign irq_ready_o = irq_valid_i && preempt && !stack_full && !finishing;
    assign accept      = irq_ready_o;

    always_comb begin
        cur_d       = cur_q;
        push_ctx    = cur_q;
        push        = 1'b0;
        pop         = 1'b0;
        taken_d     = 1'b0;
        taken_shv_d = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        if (finishing) begin
            pop       = 1'b1;
            cur_d     = stack_top;
            done_d    = 1'b1;
            done_id_d = cur_q.id[SRC_W-1:0];
        end else if (accept) begin
            push = 1'b1;
            // The preempted handler still gets credit for the accept cycle.
            if (in_handler) push_ctx.cnt = cur_q.cnt - 1'b1;
            cur_d = '{priv:  irq_priv_i,
                      level: lvl_eff,
                      id:    CLIC_ID_W'(irq_id_i),
                      shv:   irq_shv_i,
                      cnt:   CNT_W'(SVC_CYCLES)};
            taken_d     = 1'b1;
            taken_shv_d = irq_shv_i;
        end else if (in_handler) begin
            cur_d.cnt = cur_q.cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= BG_CTX;
            taken_q     <= 1'b0;
            taken_shv_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
        end else begin
            cur_q       <= cur_d;
            taken_q     <= taken_d;
            taken_shv_q <= taken_shv_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    clic_ctx_stack #(
        .NEST_DEPTH (NEST_DEPTH)
    ) u_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .pop_i      (pop),
        .push_ctx_i (push_ctx),
        .top_o      (stack_top),
        .full_o     (stack_full),
        .empty_o    (stack_empty),
        .depth_o    (depth_o)
    );

    assign cur_priv_o  = cur_q.priv;
    assign cur_level_o = cur_q.level;
    assign cur_id_o    = cur_q.id[SRC_W-1:0];
    assign taken_o     = taken_q;
    assign taken_shv_o = taken_shv_q;
    assign done_o      = done_q;
    assign done_id_o   = done_id_q;

endmodule
